// File: rtl/ps2_keyboard_fifo.sv
// PS/2 keyboard front end: pin synchroniser, clock glitch filter, frame receiver with timeout,
// E0/F0 prefix decoder with Shift/Caps tracking, scan-code to ASCII map and a FWFT event FIFO.
module ps2_keyboard_fifo #(
  parameter int FIFO_DEPTH     = 16,
  parameter int FILTER_LEN     = 4,
  parameter int TIMEOUT_CYCLES = 100000,
  parameter int REPORT_BREAK   = 0
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          ps2_clk,
  input  logic                          ps2_data,
  input  logic                          rd_en,
  output logic [7:0]                    ascii_code,
  output logic                          ascii_release,
  output logic                          ascii_extended,
  output logic                          ascii_valid,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow,
  output logic                          frame_error,
  output logic                          shift_active,
  output logic                          caps_lock
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int FW = $clog2(FILTER_LEN);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {RX_IDLE, RX_DATA, RX_PARITY, RX_STOP} rx_state_t;
  typedef enum logic [1:0] {DEC_BASE, DEC_EXT, DEC_BRK, DEC_EXTBRK} dec_state_t;

  logic            clk_s1_q, clk_s2_q, dat_s1_q, dat_s2_q;
  logic            filt_q, filt_d, filt_prev_q;
  logic [FW-1:0]   flt_cnt_q, flt_cnt_d;
  rx_state_t       rx_q, rx_d;
  logic [2:0]      bit_cnt_q, bit_cnt_d;
  logic [7:0]      sr_q, sr_d;
  logic            par_ok_q, par_ok_d;
  logic [TW-1:0]   to_cnt_q, to_cnt_d;
  dec_state_t      dec_q, dec_d;
  logic            shl_q, shl_d, shr_q, shr_d, caps_q, caps_d;
  logic            push_q, push_d;
  logic [9:0]      entry_q, entry_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            ovf_q, ovf_d;
  logic            ferr_q, ferr_d;
  logic [9:0]      mem [FIFO_DEPTH];
  logic [9:0]      head;

  logic            fall, byte_ready, err, is_make, is_break, key_ext, do_push, do_pop;
  logic [8:0]      map_w;

  // Returns {hit, ascii}; letters honour shift^caps, digits honour shift only.
  function automatic logic [8:0] map_key(input logic [7:0] code, input logic shift,
                                         input logic caps);
    logic [7:0] ch;
    logic       hit, letter;
    hit    = 1'b1;
    letter = 1'b1;
    ch     = 8'h00;
    case (code)
      8'h1C: ch = 8'h61;  8'h32: ch = 8'h62;  8'h21: ch = 8'h63;  8'h23: ch = 8'h64;
      8'h24: ch = 8'h65;  8'h2B: ch = 8'h66;  8'h34: ch = 8'h67;  8'h33: ch = 8'h68;
      8'h43: ch = 8'h69;  8'h3B: ch = 8'h6A;  8'h42: ch = 8'h6B;  8'h4B: ch = 8'h6C;
      8'h3A: ch = 8'h6D;  8'h31: ch = 8'h6E;  8'h44: ch = 8'h6F;  8'h4D: ch = 8'h70;
      8'h15: ch = 8'h71;  8'h2D: ch = 8'h72;  8'h1B: ch = 8'h73;  8'h2C: ch = 8'h74;
      8'h3C: ch = 8'h75;  8'h2A: ch = 8'h76;  8'h1D: ch = 8'h77;  8'h22: ch = 8'h78;
      8'h35: ch = 8'h79;  8'h1A: ch = 8'h7A;
      default: letter = 1'b0;
    endcase
    if (letter) begin
      if (shift ^ caps) ch = ch - 8'h20;
    end else begin
      case (code)
        8'h45: ch = shift ? 8'h29 : 8'h30;
        8'h16: ch = shift ? 8'h21 : 8'h31;
        8'h1E: ch = shift ? 8'h40 : 8'h32;
        8'h26: ch = shift ? 8'h23 : 8'h33;
        8'h25: ch = shift ? 8'h24 : 8'h34;
        8'h2E: ch = shift ? 8'h25 : 8'h35;
        8'h36: ch = shift ? 8'h5E : 8'h36;
        8'h3D: ch = shift ? 8'h26 : 8'h37;
        8'h3E: ch = shift ? 8'h2A : 8'h38;
        8'h46: ch = shift ? 8'h28 : 8'h39;
        8'h29: ch = 8'h20;
        8'h5A: ch = 8'h0D;
        8'h66: ch = 8'h08;
        8'h0D: ch = 8'h09;
        8'h76: ch = 8'h1B;
        default: hit = 1'b0;
      endcase
    end
    return {hit, ch};
  endfunction

  assign fall         = filt_prev_q & ~filt_q;
  assign map_w        = map_key(sr_q, shl_q | shr_q, caps_q);
  assign do_pop       = rd_en && (count_q != '0);
  assign do_push      = push_q && ((count_q != CW'(FIFO_DEPTH)) || do_pop);

  always_comb begin
    filt_d     = filt_q;
    flt_cnt_d  = '0;
    rx_d       = rx_q;
    bit_cnt_d  = bit_cnt_q;
    sr_d       = sr_q;
    par_ok_d   = par_ok_q;
    to_cnt_d   = to_cnt_q;
    dec_d      = dec_q;
    shl_d      = shl_q;
    shr_d      = shr_q;
    caps_d     = caps_q;
    push_d     = 1'b0;
    entry_d    = entry_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    ovf_d      = ovf_q;
    byte_ready = 1'b0;
    err        = 1'b0;
    is_make    = 1'b0;
    is_break   = 1'b0;
    key_ext    = 1'b0;

    if (clk_s2_q != filt_q) begin
      if (flt_cnt_q == FW'(FILTER_LEN - 1)) filt_d = clk_s2_q;
      else                                  flt_cnt_d = flt_cnt_q + 1'b1;
    end

    case (rx_q)
      RX_IDLE: begin
        to_cnt_d = '0;
        if (fall && !dat_s2_q) begin
          rx_d      = RX_DATA;
          bit_cnt_d = '0;
        end
      end
      RX_DATA: if (fall) begin
        sr_d      = {dat_s2_q, sr_q[7:1]};
        bit_cnt_d = bit_cnt_q + 1'b1;
        if (bit_cnt_q == 3'd7) rx_d = RX_PARITY;
      end
      RX_PARITY: if (fall) begin
        par_ok_d = ^{sr_q, dat_s2_q};
        rx_d     = RX_STOP;
      end
      RX_STOP: if (fall) begin
        rx_d = RX_IDLE;
        if (dat_s2_q && par_ok_q) byte_ready = 1'b1;
        else                      err        = 1'b1;
      end
    endcase

    // Mid-frame watchdog: only counts while a frame is open and no edge arrives.
    if (rx_q != RX_IDLE && !fall) begin
      if (to_cnt_q == TW'(TIMEOUT_CYCLES)) begin
        err      = 1'b1;
        rx_d     = RX_IDLE;
        to_cnt_d = '0;
      end else begin
        to_cnt_d = to_cnt_q + 1'b1;
      end
    end else if (fall) begin
      to_cnt_d = '0;
    end

    if (err) begin
      dec_d = DEC_BASE;
    end else if (byte_ready) begin
      case (dec_q)
        DEC_BASE: begin
          if      (sr_q == 8'hE0) dec_d = DEC_EXT;
          else if (sr_q == 8'hF0) dec_d = DEC_BRK;
          else                    is_make = 1'b1;
        end
        DEC_EXT: begin
          if (sr_q == 8'hF0) dec_d = DEC_EXTBRK;
          else begin
            is_make = 1'b1;
            key_ext = 1'b1;
            dec_d   = DEC_BASE;
          end
        end
        DEC_BRK: begin
          is_break = 1'b1;
          dec_d    = DEC_BASE;
        end
        DEC_EXTBRK: begin
          is_break = 1'b1;
          key_ext  = 1'b1;
          dec_d    = DEC_BASE;
        end
      endcase
    end

    if (is_make) begin
      if      (sr_q == 8'h12) shl_d  = 1'b1;
      else if (sr_q == 8'h59) shr_d  = 1'b1;
      else if (sr_q == 8'h58) caps_d = ~caps_q;
      else if (map_w[8]) begin
        push_d  = 1'b1;
        entry_d = {1'b0, key_ext, map_w[7:0]};
      end
    end else if (is_break) begin
      if      (sr_q == 8'h12) shl_d = 1'b0;
      else if (sr_q == 8'h59) shr_d = 1'b0;
      else if (REPORT_BREAK != 0 && map_w[8]) begin
        push_d  = 1'b1;
        entry_d = {1'b1, key_ext, map_w[7:0]};
      end
    end

    // Full FIFO still accepts a push when the same cycle pops.
    if (push_q && !do_push) ovf_d = 1'b1;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  assign ferr_d = err;

  always_ff @(posedge clk) begin
    if (reset) begin
      clk_s1_q    <= 1'b1;
      clk_s2_q    <= 1'b1;
      dat_s1_q    <= 1'b1;
      dat_s2_q    <= 1'b1;
      filt_q      <= 1'b1;
      filt_prev_q <= 1'b1;
      flt_cnt_q   <= '0;
      rx_q        <= RX_IDLE;
      bit_cnt_q   <= '0;
      par_ok_q    <= 1'b0;
      to_cnt_q    <= '0;
      dec_q       <= DEC_BASE;
      shl_q       <= 1'b0;
      shr_q       <= 1'b0;
      caps_q      <= 1'b0;
      push_q      <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      ovf_q       <= 1'b0;
      ferr_q      <= 1'b0;
    end else begin
      clk_s1_q    <= ps2_clk;
      clk_s2_q    <= clk_s1_q;
      dat_s1_q    <= ps2_data;
      dat_s2_q    <= dat_s1_q;
      filt_q      <= filt_d;
      filt_prev_q <= filt_q;
      flt_cnt_q   <= flt_cnt_d;
      rx_q        <= rx_d;
      bit_cnt_q   <= bit_cnt_d;
      par_ok_q    <= par_ok_d;
      to_cnt_q    <= to_cnt_d;
      dec_q       <= dec_d;
      shl_q       <= shl_d;
      shr_q       <= shr_d;
      caps_q      <= caps_d;
      push_q      <= push_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      ovf_q       <= ovf_d;
      ferr_q      <= ferr_d;
    end
    sr_q    <= sr_d;
    entry_q <= entry_d;
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_q] <= entry_q;
  end

  assign head           = mem[rd_ptr_q];
  assign ascii_valid    = (count_q != '0);
  assign ascii_code     = ascii_valid ? head[7:0] : 8'h00;
  assign ascii_extended = ascii_valid & head[8];
  assign ascii_release  = ascii_valid & head[9];
  assign fifo_count     = count_q;
  assign overflow       = ovf_q;
  assign frame_error    = ferr_q;
  assign shift_active   = shl_q | shr_q;
  assign caps_lock      = caps_q;

endmodule

// File: tb/tb_ps2_keyboard_fifo.sv
// Directed bench for ps2_keyboard_fifo: two instances share the PS/2 pins, one with a 4-deep
// FIFO reporting releases, one with a 16-deep FIFO that does not.
module tb_ps2_keyboard_fifo;

  localparam int HALF = 20;
  localparam int TO   = 200;

  logic       clk = 1'b0, reset = 1'b1, ps2_clk = 1'b1, ps2_data = 1'b1;
  logic       rd_en1 = 1'b0, rd_en0 = 1'b0;
  logic [7:0] code1, code0;
  logic       rel1, ext1, vld1, ovf1, fe1, sh1, caps1;
  logic       rel0, ext0, vld0, ovf0, fe0, sh0, caps0;
  logic [2:0] cnt1;
  logic [4:0] cnt0;
  int         tests = 0, fails = 0, fe1_cnt = 0;

  ps2_keyboard_fifo #(.FIFO_DEPTH(4), .FILTER_LEN(4), .TIMEOUT_CYCLES(TO), .REPORT_BREAK(1)) dut1 (
    .clk(clk), .reset(reset), .ps2_clk(ps2_clk), .ps2_data(ps2_data), .rd_en(rd_en1),
    .ascii_code(code1), .ascii_release(rel1), .ascii_extended(ext1), .ascii_valid(vld1),
    .fifo_count(cnt1), .overflow(ovf1), .frame_error(fe1), .shift_active(sh1),
    .caps_lock(caps1));

  ps2_keyboard_fifo #(.FIFO_DEPTH(16), .FILTER_LEN(4), .TIMEOUT_CYCLES(TO), .REPORT_BREAK(0)) dut0 (
    .clk(clk), .reset(reset), .ps2_clk(ps2_clk), .ps2_data(ps2_data), .rd_en(rd_en0),
    .ascii_code(code0), .ascii_release(rel0), .ascii_extended(ext0), .ascii_valid(vld0),
    .fifo_count(cnt0), .overflow(ovf0), .frame_error(fe0), .shift_active(sh0),
    .caps_lock(caps0));

  always #5 clk = ~clk;

  always @(negedge clk) if (fe1) fe1_cnt++;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk) reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic ps2_bit(input logic b);
    @(negedge clk) ps2_data = b;
    repeat (HALF) @(negedge clk);
    ps2_clk = 1'b0;
    repeat (HALF) @(negedge clk);
    ps2_clk = 1'b1;
  endtask

  task automatic send(input logic [7:0] code, input logic bad_par = 1'b0);
    logic [10:0] bits;
    bits = {1'b1, (~^code) ^ bad_par, code, 1'b0};
    for (int i = 0; i < 11; i++) ps2_bit(bits[i]);
    repeat (HALF) @(negedge clk);
  endtask

  // Everything up to the stop-bit falling edge, which lands just before the next posedge.
  task automatic frame_head(input logic [7:0] code);
    logic [10:0] bits;
    bits = {1'b1, ~^code, code, 1'b0};
    for (int i = 0; i < 10; i++) ps2_bit(bits[i]);
    @(negedge clk) ps2_data = 1'b1;
    repeat (HALF) @(negedge clk);
    ps2_clk = 1'b0;
  endtask

  task automatic frame_tail();
    repeat (HALF) @(negedge clk);
    ps2_clk = 1'b1;
    repeat (HALF) @(negedge clk);
  endtask

  task automatic pop1(input string tag, input logic [7:0] c, input logic r, input logic e);
    @(negedge clk);
    chk({tag, "_vld"}, vld1, 1'b1);
    chk({tag, "_code"}, code1, c);
    chk({tag, "_rel_ext"}, {rel1, ext1}, {r, e});
    rd_en1 = 1'b1;
    @(negedge clk) rd_en1 = 1'b0;
  endtask

  task automatic pop0(input string tag, input logic [7:0] c, input logic r, input logic e);
    @(negedge clk);
    chk({tag, "_vld"}, vld0, 1'b1);
    chk({tag, "_code"}, code0, c);
    chk({tag, "_rel_ext"}, {rel0, ext0}, {r, e});
    rd_en0 = 1'b1;
    @(negedge clk) rd_en0 = 1'b0;
  endtask

  initial begin
    int fe_base;
    do_reset();
    chk("reset_out1", {code1, rel1, ext1, vld1, cnt1, ovf1, fe1, sh1, caps1}, 32'h0);
    chk("reset_out0", {code0, rel0, ext0, vld0, cnt0, ovf0, fe0, sh0, caps0}, 32'h0);

    // Latency: stop-bit edge -> 2 sync + 4 filter + edge detect + push + write.
    frame_head(8'h1C);
    repeat (7) @(posedge clk);
    #1 chk("lat_vld_early", vld1, 1'b0);
    @(posedge clk);
    #1 chk("lat_vld_rise", vld1, 1'b1);
    chk("lat_vld_rise0", vld0, 1'b1);
    frame_tail();
    pop1("lat", 8'h61, 1'b0, 1'b0);
    @(negedge clk) chk("lat_empty", vld1, 1'b0);

    // Shift make/break with release reporting.
    do_reset();
    send(8'h12);
    chk("shift_on", sh1, 1'b1);
    send(8'h1C); send(8'hF0); send(8'h1C); send(8'hF0); send(8'h12);
    chk("shift_off", sh1, 1'b0);
    send(8'h1C);
    chk("shift_cnt", cnt1, 3'd3);
    pop1("sh_A", 8'h41, 1'b0, 1'b0);
    pop1("sh_Ar", 8'h41, 1'b1, 1'b0);
    pop1("sh_a", 8'h61, 1'b0, 1'b0);

    // Caps lock toggles letters only; shifted digit.
    do_reset();
    send(8'h58); send(8'hF0); send(8'h58);
    chk("caps_on", caps1, 1'b1);
    send(8'h1C); send(8'h12); send(8'h16);
    pop1("caps_A", 8'h41, 1'b0, 1'b0);
    pop1("caps_bang", 8'h21, 1'b0, 1'b0);
    chk("caps_still", caps1, 1'b1);

    // Bad parity.
    do_reset();
    fe_base = fe1_cnt;
    send(8'h1C, 1'b1);
    chk("par_fe", fe1_cnt - fe_base, 1);
    chk("par_noentry", cnt1, 3'd0);

    // Timeout after a partial frame, then a clean frame.
    do_reset();
    fe_base = fe1_cnt;
    ps2_bit(1'b0); ps2_bit(1'b0); ps2_bit(1'b0); ps2_bit(1'b1);
    repeat (TO + 50) @(negedge clk);
    chk("to_fe", fe1_cnt - fe_base, 1);
    send(8'h29);
    pop1("to_space", 8'h20, 1'b0, 1'b0);

    // FIFO full: push+pop same cycle, then a dropped push.
    do_reset();
    send(8'h1C); send(8'h32); send(8'h21); send(8'h23);
    chk("full_cnt", cnt1, 3'd4);
    chk("full_noovf", ovf1, 1'b0);
    frame_head(8'h24);
    repeat (7) @(posedge clk);
    #1 rd_en1 = 1'b1;
    @(posedge clk);
    #1 rd_en1 = 1'b0;
    frame_tail();
    chk("pp_cnt", cnt1, 3'd4);
    chk("pp_noovf", ovf1, 1'b0);
    send(8'h2B);
    chk("ovf_cnt", cnt1, 3'd4);
    chk("ovf_set", ovf1, 1'b1);
    pop1("ff_b", 8'h62, 1'b0, 1'b0);
    pop1("ff_c", 8'h63, 1'b0, 1'b0);
    pop1("ff_d", 8'h64, 1'b0, 1'b0);
    pop1("ff_e", 8'h65, 1'b0, 1'b0);
    @(negedge clk);
    chk("ff_empty", vld1, 1'b0);
    chk("ovf_sticky", ovf1, 1'b1);

    // Extended keys.
    do_reset();
    send(8'hE0); send(8'h5A); send(8'hE0); send(8'hF0); send(8'h5A);
    chk("ext_cnt0", cnt0, 5'd1);
    pop0("ext0", 8'h0D, 1'b0, 1'b1);
    @(negedge clk) chk("ext0_empty", vld0, 1'b0);
    chk("ext_cnt1", cnt1, 3'd2);
    pop1("ext1_mk", 8'h0D, 1'b0, 1'b1);
    pop1("ext1_brk", 8'h0D, 1'b1, 1'b1);

    // Reset mid-frame.
    do_reset();
    send(8'h12); send(8'h1C);
    chk("mid_pre_vld", vld1, 1'b1);
    ps2_bit(1'b0); ps2_bit(1'b1); ps2_bit(1'b0);
    do_reset();
    chk("mid_out1", {code1, rel1, ext1, vld1, cnt1, ovf1, fe1, sh1, caps1}, 32'h0);
    chk("mid_out0", {code0, rel0, ext0, vld0, cnt0, ovf0, fe0, sh0, caps0}, 32'h0);
    repeat (HALF) @(negedge clk);
    send(8'h1C);
    pop1("mid_a", 8'h61, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
